// File: rtl/div8_seq.sv
// div8_seq: sequential restoring divider, one quotient bit per clock.
// Start -> done latency is 9 cycles (1 cycle on divide-by-zero).
// Optional feature macro: DIV8_SIGNED_EN (two's-complement operands with
// sign correction of quotient/remainder). Undefined: unsigned only.
module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   part;     // partial remainder (9 bits)
    logic [WIDTH-1:0] qsr;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] raw_dvd;  // unmodified dividend, returned on divide-by-zero
    logic             dz_pend;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

`ifdef DIV8_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Operand magnitudes via ~x+1; -128 maps to 8'h80, which is its unsigned magnitude
    always_comb begin
        dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    end

    // Sign correction: quotient negative when signs differ, remainder follows dividend
    always_comb begin
        res_q = neg_q ? (~qsr + 1'b1) : qsr;
        res_r = neg_r ? (~part[WIDTH-1:0] + 1'b1) : part[WIDTH-1:0];
    end
`else
    // Unsigned build: operands and results pass straight through
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        res_q   = qsr;
        res_r   = part[WIDTH-1:0];
    end
`endif

    // Trial subtraction of the left-shifted partial remainder; the top bit is the borrow
    always_comb begin
        sh    = {part, qsr[WIDTH-1]};
        trial = sh - {2'b00, dvs};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            part      <= '0;
            qsr       <= '0;
            dvs       <= '0;
            raw_dvd   <= '0;
            dz_pend   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
`ifdef DIV8_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        raw_dvd <= dividend;
                        part    <= '0;
                        qsr     <= dvd_mag;
                        dvs     <= dvs_mag;
                        cnt     <= CW'(WIDTH - 1);
`ifdef DIV8_SIGNED_EN
                        neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r   <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            dz_pend <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            dz_pend <= 1'b0;
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // borrow set means the trial went negative: restore and shift in 0
                    if (trial[WIDTH+1]) begin
                        part <= sh[WIDTH:0];
                        qsr  <= {qsr[WIDTH-2:0], 1'b0};
                    end else begin
                        part <= trial[WIDTH:0];
                        qsr  <= {qsr[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (dz_pend) begin
                        quotient  <= '1;
                        remainder <= raw_dvd;
                        dbz       <= 1'b1;
                    end else begin
                        quotient  <= res_q;
                        remainder <= res_r;
                        dbz       <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
